// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor (diff = a - b), LSB first, one bit per
//   clock. A single full-subtractor cell plus a registered borrow flip-flop.
//   A start/done handshake frames each operation.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   start       request; sampled only while ready=1
//   a, b        minuend / subtrahend, captured on the accepted start edge
//   ready       high in IDLE only
//   busy        high in SHIFT
//   done        one-cycle pulse when diff/borrow_out/overflow are valid
//   diff        a - b modulo 2^WIDTH (held until the next completion)
//   borrow_out  final borrow; 1 means a < b unsigned
//   overflow    signed two's-complement overflow of a - b
// ---------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_sa;
  logic [WIDTH-1:0]   r_sb;
  logic [WIDTH-2:0]   r_res;     // difference bits produced so far
  logic               r_br;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_a;
  logic               w_b;
  logic               w_d;
  logic               w_br_next;
  logic               w_last;
  logic [WIDTH-1:0]   w_res_next;

  // Full-subtractor cell on the current LSBs of the operand shift registers.
  always_comb begin
    w_a        = r_sa[0];
    w_b        = r_sb[0];
    w_d        = w_a ^ w_b ^ r_br;
    w_br_next  = (~w_a & w_b) | (~(w_a ^ w_b) & r_br);
    w_last     = (r_cnt == CNT_W'(WIDTH - 1));
    w_res_next = {w_d, r_res};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_sa       <= '0;
      r_sb       <= '0;
      r_res      <= '0;
      r_br       <= 1'b0;
      r_cnt      <= '0;
      ready      <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sa    <= a;
            r_sb    <= b;
            r_res   <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            ready   <= 1'b0;
            busy    <= 1'b1;
            r_state <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_res <= w_res_next[WIDTH-1:1];
          r_br  <= w_br_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            // On the last bit the operand LSBs are the original MSBs,
            // so the sign bits needed for overflow are w_a / w_b.
            diff       <= w_res_next;
            borrow_out <= w_br_next;
            overflow   <= (w_a != w_b) && (w_d != w_a);
            busy       <= 1'b0;
            done       <= 1'b1;
            r_state    <= S_DONE;
          end
        end

        S_DONE: begin
          done    <= 1'b0;
          ready   <= 1'b1;
          r_state <= S_IDLE;
        end

        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          ready   <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
//   Directed, self-checking bench for serial_subtractor (WIDTH=8).
//   Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             overflow;

  int n_checks = 0;
  int n_errors = 0;

  // Result values the outputs must hold between completions.
  logic [WIDTH-1:0] m_diff;
  logic             m_bo;
  logic             m_ov;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // mode 0: plain operation
  // mode 1: extra start pulse (with new operands) during SHIFT, must be ignored
  // mode 2: reset after 4 SHIFT edges, must abort with no done
  task automatic run_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                        input logic [WIDTH-1:0] ed, input logic ebo, input logic eov,
                        input int mode);
    int n_done;
    check("pre_ready", ready, 1);
    a     = ia;
    b     = ib;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a     = ~ia;   // operand changes after acceptance must not matter
    b     = ~ib;
    check("acc_busy", busy, 1);
    check("acc_ready", ready, 0);
    for (int k = 1; k <= WIDTH; k++) begin
      if (mode == 2 && k == 5) begin
        rst = 1'b1;
        #1;
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_bo", borrow_out, 0);
        check("rst_ov", overflow, 0);
        @(posedge clk); #1;
        rst    = 1'b0;
        m_diff = '0;
        m_bo   = 1'b0;
        m_ov   = 1'b0;
        n_done = 0;
        for (int j = 0; j < WIDTH + 4; j++) begin
          @(posedge clk); #1;
          if (done) n_done++;
        end
        check("abort_no_done", n_done, 0);
        check("abort_ready", ready, 1);
        check("abort_diff", diff, 0);
        return;
      end
      @(posedge clk); #1;
      if (k < WIDTH) begin
        check("shift_busy", busy, 1);
        check("shift_done", done, 0);
        check("shift_hold_diff", diff, m_diff);
        check("shift_hold_bo", borrow_out, m_bo);
        check("shift_hold_ov", overflow, m_ov);
      end else begin
        check("done_pulse", done, 1);
        check("done_busy", busy, 0);
        check("done_ready", ready, 0);
        check("diff", diff, ed);
        check("borrow_out", borrow_out, ebo);
        check("overflow", overflow, eov);
      end
      if (mode == 1 && k == 3) begin
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'h00;
      end
      if (mode == 1 && k == 4) start = 1'b0;
    end
    m_diff = ed;
    m_bo   = ebo;
    m_ov   = eov;
    @(posedge clk); #1;
    check("post_done", done, 0);
    check("post_ready", ready, 1);
    check("post_diff", diff, ed);
    if (mode == 1) begin
      n_done = 0;
      for (int j = 0; j < 20; j++) begin
        @(posedge clk); #1;
        if (done) n_done++;
      end
      check("no_extra_done", n_done, 0);
      check("idle_diff_hold", diff, ed);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    m_diff = '0;
    m_bo   = 1'b0;
    m_ov   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("in_rst_ready", ready, 1);
    check("in_rst_busy", busy, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("reset_ready", ready, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_diff", diff, 8'h00);
    check("reset_bo", borrow_out, 0);
    check("reset_ov", overflow, 0);

    run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 0);
    run_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 0);
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 0);
    run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 0);
    run_op(8'h3C, 8'h3C, 8'h00, 1'b0, 1'b0, 0);  // a == b
    run_op(8'h9A, 8'h00, 8'h9A, 1'b0, 1'b0, 0);  // b == 0
    run_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 0);
    run_op(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 1);  // ignored start mid-op
    run_op(8'hAA, 8'h55, 8'h00, 1'b0, 1'b0, 2);  // reset abort
    run_op(8'hAA, 8'h55, 8'h55, 1'b0, 1'b1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
